ippcrc_crc32_stream: RTL and testbench
======================================

# ippcrc_crc32_stream

Parametrised, registered CRC-32 engine for packet streams. Accepts one DW-bit data word per clock with start/end-of-packet markers and a valid-byte count on the final word. In generate mode it produces the packet FCS; in check mode it compares the running remainder against the CRC-32 residue. It sits between packet framers and MAC/encapsulation logic and replaces fixed-width combinational CRC slices wherever packet boundaries and partial last words must be handled.

## Interface
- DW, 96: data word width in bits; a multiple of 8, from 8 to 128.
- POLY, 32'h04C11DB7: generator polynomial, normal (non-reflected) form.
- INIT, 32'hFFFFFFFF: remainder register value loaded at start of packet.
- XOROUT, 32'hFFFFFFFF: value XORed into the remainder to form o_crc.
- RESIDUE, 32'hC704DD7B: expected remainder, before XOROUT, after payload plus FCS in check mode.
- NBW, $clog2(DW/8)+1: width of i_nbyte.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_vld  in  1  input word valid; no backpressure, so a valid word is always accepted.
- i_sop  in  1  first word of packet; qualified by i_vld.
- i_eop  in  1  last word of packet; qualified by i_vld; may coincide with i_sop.
- i_nbyte  in  NBW  valid bytes on the eop word; 1..DW/8; 0 or >DW/8 is treated as DW/8; ignored when i_eop=0.
- i_chk  in  1  mode, sampled with i_sop: 0 = generate, 1 = check.
- i_dat  in  DW  data; byte k = i_dat[8k+7:8k]; byte 0 first on the wire; bit 0 of each byte processed first.
- o_vld  out  1  one-cycle pulse: packet result valid.
- o_crc  out  32  remainder XOR XOROUT; bit 31 = coefficient of x^31; held until next o_vld.
- o_err  out  1  check mode: remainder != RESIDUE; generate mode: 0; valid with o_vld.
- o_seqerr  out  1  one-cycle pulse: framing violation.
- o_busy  out  1  state is PKT.

## Operation
- The remainder register r[31:0] updates per processed bit b: fb = r[31]^b; r = {r[30:0],1'b0} ^ (fb ? POLY : 0).
- One accepted word applies this update over bytes 0..n-1 in order, with n = DW/8, or n = i_nbyte on an eop word. Bytes n..DW/8-1 are ignored.
- Implement as a per-byte unrolled XOR matrix with an n-select mux. The whole update completes within one cycle.
- Two-state FSM, IDLE / PKT:
  - IDLE, vld&sop&!eop: r = update(INIT, word); mode latched from i_chk; go to PKT.
  - IDLE, vld&sop&eop: single-word packet; result issued; stay IDLE.
  - IDLE, vld&!sop: word dropped; o_seqerr pulses; r unchanged.
  - PKT, vld&!sop&!eop: r = update(r, word).
  - PKT, vld&!sop&eop: final update; result issued; go to IDLE.
  - PKT, vld&sop: current packet is abandoned with no o_vld; o_seqerr pulses; the word starts a new packet from INIT, so the IDLE-with-sop rules apply.
  - PKT, !vld: hold; idle gaps of any length are legal mid-packet.
- On result: o_crc = r_final ^ XOROUT; o_err = chk_latched & (r_final != RESIDUE).
- Reset, asynchronous: state IDLE, r = INIT, mode 0, o_vld = 0, o_crc = 0, o_err = 0, o_seqerr = 0, o_busy = 0.
- Reset asserted mid-packet discards the packet, and no o_vld is produced.

## Timing
- Latency: o_vld, o_crc and o_err are registered and appear in the cycle after the eop word is accepted.
- Throughput: one word per clock, sustained. Back-to-back packets are supported (eop at cycle t, sop at t+1) with no bubble, and an o_vld at t+1 overlaps the new packet.
- o_seqerr is registered and asserts one cycle after the offending word.
- o_busy is registered and asserts in the cycle after a multi-word sop.
- The critical path is one DW-bit update plus the byte-count mux; if timing fails, the team will split it at a pipeline register later, and this spec fixes latency = 1.

## Test plan
- Generate, DW=96: one word, sop=eop=1, nbyte=9, bytes "123456789" (31..39 hex) -> next cycle o_vld=1, o_crc=32'h649C2FD3, o_err=0.
- Check mode:
  - Good packet: word 1 is "123456789" followed by 26 39 F4; word 2 is CB with nbyte=1 -> o_crc=32'h38FB2284, o_err=0.
  - Same packet with byte 0 flipped to 0x30 -> o_err=1.
- Gaps and back-to-back: the previous packet split over 2 words with 3 idle cycles between them, immediately followed by a repeat -> two identical results 1 cycle after each eop; o_busy is low only between packets.
- Framing:
  - Data with no sop in IDLE -> o_seqerr pulse, no o_vld.
  - sop mid-packet -> o_seqerr; the later result equals the CRC of the new packet only.
- Reset and partial words:
  - rst asserted mid-packet -> all outputs 0; the next clean packet gives the reference value.
  - nbyte=0 gives the same result as nbyte=12.
  - Random lengths 1..200 bytes against a bitwise model.

Source files
------------

// File: rtl/ippcrc_crc32_stream.sv
// Registered CRC-32 engine for packet streams: one DW-bit word per clock,
// sop/eop framing, partial final word, generate (FCS) and check (residue) modes.
module ippcrc_crc32_stream #(
  parameter int          DW      = 96,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE = 32'hC704DD7B,
  parameter int          NBW     = $clog2(DW/8) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic [NBW-1:0]    i_nbyte,
  input  logic              i_chk,
  input  logic [DW-1:0]     i_dat,
  output logic              o_vld,
  output logic [31:0]       o_crc,
  output logic              o_err,
  output logic              o_seqerr,
  output logic              o_busy
);

  localparam int NB = DW / 8;

  typedef enum logic [0:0] {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t          state_r;
  logic [31:0]     crc_r;
  logic            chk_r;

  logic [31:0]     base_s;
  logic [31:0]     next_s;
  logic [NBW-1:0]  n_s;
  logic            mode_s;
  logic            err_s;
  logic [31:0]     stage_s [0:NB];

  // One byte of the serial update, bit 0 of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] r, input logic [7:0] b);
    logic [31:0] c;
    c = r;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ b[i]) begin
        c = {c[30:0], 1'b0} ^ POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Effective byte count: full word unless an in-range count is given on eop.
  always_comb begin
    n_s = NBW'(NB);
    if (i_eop && (i_nbyte != '0) && (i_nbyte <= NBW'(NB))) begin
      n_s = i_nbyte;
    end else begin
      n_s = NBW'(NB);
    end
  end

  // Byte-unrolled update chain from the packet seed, then one-hot tap select.
  always_comb begin
    base_s = i_sop ? INIT : crc_r;
    stage_s[0] = base_s;
    for (int k = 0; k < NB; k++) begin
      stage_s[k+1] = crc_byte(stage_s[k], i_dat[8*k +: 8]);
    end
    next_s = 32'h0000_0000;
    for (int k = 1; k <= NB; k++) begin
      next_s = next_s | (stage_s[k] & {32{n_s == NBW'(k)}});
    end
    mode_s = i_sop ? i_chk : chk_r;
    err_s  = mode_s & (next_s != RESIDUE);
  end

  // Framing FSM, remainder register and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      crc_r    <= INIT;
      chk_r    <= 1'b0;
      o_vld    <= 1'b0;
      o_crc    <= 32'h0000_0000;
      o_err    <= 1'b0;
      o_seqerr <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      o_vld    <= 1'b0;
      o_seqerr <= 1'b0;
      if (i_vld && i_sop) begin
        // A sop inside a packet abandons it silently apart from the seqerr flag.
        o_seqerr <= (state_r == PKT);
        chk_r    <= i_chk;
        if (i_eop) begin
          o_vld   <= 1'b1;
          o_crc   <= next_s ^ XOROUT;
          o_err   <= err_s;
          crc_r   <= INIT;
          state_r <= IDLE;
          o_busy  <= 1'b0;
        end else begin
          crc_r   <= next_s;
          state_r <= PKT;
          o_busy  <= 1'b1;
        end
      end else if (i_vld) begin
        case (state_r)
          IDLE: begin
            o_seqerr <= 1'b1;
          end
          PKT: begin
            if (i_eop) begin
              o_vld   <= 1'b1;
              o_crc   <= next_s ^ XOROUT;
              o_err   <= err_s;
              crc_r   <= INIT;
              state_r <= IDLE;
              o_busy  <= 1'b0;
            end else begin
              crc_r   <= next_s;
            end
          end
          default: begin
            state_r <= IDLE;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ippcrc_crc32_stream.sv
// Self-checking bench for ippcrc_crc32_stream (DW=96): vector table, framing
// sequences and random packets against a reflected-form CRC-32 model.
module tb_ippcrc_crc32_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vld, i_sop, i_eop, i_chk;
  logic [4:0]  i_nbyte;
  logic [95:0] i_dat;
  logic        o_vld, o_err, o_seqerr, o_busy;
  logic [31:0] o_crc;

  int checks   = 0;
  int failures = 0;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    logic [95:0] dat;
    logic [4:0]  nbyte;
    logic        chk;
    logic [31:0] crc;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  localparam logic [95:0] W_123 = 96'h00000039_38373635_34333231;
  localparam logic [95:0] W_C1  = 96'hF4392639_38373635_34333231;
  localparam logic [95:0] W_C1X = 96'hF4392639_38373635_34333230;
  localparam logic [95:0] W_C2  = 96'h00000000_00000000_000000CB;
  localparam logic [95:0] W_12B = 96'h01234567_89ABCDEF_FEDCBA98;
  localparam logic [31:0] GOOD  = 32'h38FB2284;

  ippcrc_crc32_stream dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop),
    .i_nbyte(i_nbyte), .i_chk(i_chk), .i_dat(i_dat),
    .o_vld(o_vld), .o_crc(o_crc), .o_err(o_err), .o_seqerr(o_seqerr), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Reference: standard reflected CRC-32, mapped to the non-reflected output order.
  function automatic logic [31:0] model_crc(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h000000, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return bitrev(~c);
  endfunction

  function automatic bq_t word2q(input logic [95:0] d, input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(d[8*k +: 8]);
    return q;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic idle();
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drive_word(input logic [95:0] dat, input logic sop, input logic eop,
                            input logic [4:0] nb, input logic chk);
    i_dat = dat; i_sop = sop; i_eop = eop; i_nbyte = nb; i_chk = chk; i_vld = 1'b1;
    @(posedge clk); #1;
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic send_pkt(input bq_t b, input logic chk, input int gap);
    int n, idx, cnt;
    logic [95:0] w;
    n = b.size();
    idx = 0;
    while (idx < n) begin
      cnt = (n - idx > 12) ? 12 : (n - idx);
      w = '0;
      for (int k = 0; k < cnt; k++) w[8*k +: 8] = b[idx+k];
      drive_word(w, idx == 0, idx + cnt >= n, 5'(cnt), chk);
      if (idx + cnt < n) begin
        check1("mid_vld", o_vld, 1'b0);
        check1("mid_busy", o_busy, 1'b1);
        repeat (gap) idle();
      end
      idx += cnt;
    end
  endtask

  initial begin
    bq_t pkt;
    logic [31:0] exp_crc, std;
    logic        chk, exp_err;
    int          len;

    rst = 1'b1; i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_chk = 1'b0;
    i_nbyte = 5'd0; i_dat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check1("rst_vld", o_vld, 1'b0);
    check("rst_crc", o_crc, 32'h0);
    check1("rst_err", o_err, 1'b0);
    check1("rst_seqerr", o_seqerr, 1'b0);
    check1("rst_busy", o_busy, 1'b0);

    // Single-word packet table.
    vecs[0] = '{W_123, 5'd9, 1'b0, 32'h649C2FD3, 1'b0};
    vecs[1] = '{96'h61, 5'd1, 1'b0, 32'hC27DED17, 1'b0};
    vecs[2] = '{96'h636261, 5'd3, 1'b0, 32'h438224AC, 1'b0};
    vecs[3] = '{96'hDEADBEEF_AA55AA55_FF636261, 5'd3, 1'b0, 32'h438224AC, 1'b0};
    vecs[4] = '{W_123, 5'd9, 1'b1, 32'h649C2FD3, 1'b1};
    vecs[5] = '{W_12B, 5'd12, 1'b0, 32'h0, 1'b0};
    vecs[6] = '{W_12B, 5'd0, 1'b0, 32'h0, 1'b0};
    vecs[7] = '{W_12B, 5'd13, 1'b0, 32'h0, 1'b0};
    vecs[8] = '{96'h00000000_00352441_C2636261, 5'd7, 1'b1, GOOD, 1'b0};
    for (int v = 5; v <= 7; v++) vecs[v].crc = model_crc(word2q(W_12B, 12));

    for (int v = 0; v < 9; v++) begin
      drive_word(vecs[v].dat, 1'b1, 1'b1, vecs[v].nbyte, vecs[v].chk);
      check1($sformatf("vec%0d_vld", v), o_vld, 1'b1);
      check($sformatf("vec%0d_crc", v), o_crc, vecs[v].crc);
      check1($sformatf("vec%0d_err", v), o_err, vecs[v].err);
      check1($sformatf("vec%0d_busy", v), o_busy, 1'b0);
    end
    idle();
    check1("vld_pulse", o_vld, 1'b0);

    // Check mode, two words with idle gaps, then a back-to-back repeat.
    drive_word(W_C1, 1'b1, 1'b0, 5'd12, 1'b1);
    check1("gap_busy0", o_busy, 1'b1);
    for (int g = 0; g < 3; g++) begin
      idle();
      check1("gap_busy", o_busy, 1'b1);
      check1("gap_vld", o_vld, 1'b0);
    end
    drive_word(W_C2, 1'b0, 1'b1, 5'd1, 1'b1);
    check1("chk1_vld", o_vld, 1'b1);
    check("chk1_crc", o_crc, GOOD);
    check1("chk1_err", o_err, 1'b0);
    check1("chk1_busy", o_busy, 1'b0);
    drive_word(W_C1, 1'b1, 1'b0, 5'd12, 1'b1);
    check1("b2b_vld", o_vld, 1'b0);
    check1("b2b_busy", o_busy, 1'b1);
    repeat (3) idle();
    drive_word(W_C2, 1'b0, 1'b1, 5'd1, 1'b1);
    check1("chk2_vld", o_vld, 1'b1);
    check("chk2_crc", o_crc, GOOD);
    check1("chk2_err", o_err, 1'b0);
    idle();
    check("crc_hold", o_crc, GOOD);

    // Corrupted byte 0 in check mode.
    drive_word(W_C1X, 1'b1, 1'b0, 5'd12, 1'b1);
    drive_word(W_C2, 1'b0, 1'b1, 5'd1, 1'b1);
    pkt = word2q(W_C1X, 12);
    pkt.push_back(8'hCB);
    check1("bad_vld", o_vld, 1'b1);
    check("bad_crc", o_crc, model_crc(pkt));
    check1("bad_err", o_err, 1'b1);

    // Data without sop while idle.
    idle();
    drive_word(W_123, 1'b0, 1'b1, 5'd9, 1'b0);
    check1("nosop_seqerr", o_seqerr, 1'b1);
    check1("nosop_vld", o_vld, 1'b0);
    check1("nosop_busy", o_busy, 1'b0);
    idle();
    check1("seqerr_pulse", o_seqerr, 1'b0);

    // sop mid-packet restarts; the result covers only the new packet.
    drive_word(W_12B, 1'b1, 1'b0, 5'd12, 1'b0);
    drive_word(W_C1, 1'b1, 1'b0, 5'd12, 1'b1);
    check1("resop_seqerr", o_seqerr, 1'b1);
    check1("resop_vld", o_vld, 1'b0);
    check1("resop_busy", o_busy, 1'b1);
    drive_word(W_C2, 1'b0, 1'b1, 5'd1, 1'b1);
    check1("resop_vld2", o_vld, 1'b1);
    check("resop_crc", o_crc, GOOD);
    check1("resop_err", o_err, 1'b0);
    check1("resop_seqerr2", o_seqerr, 1'b0);

    // Asynchronous reset mid-packet.
    drive_word(W_C1, 1'b1, 1'b0, 5'd12, 1'b0);
    check1("prerst_busy", o_busy, 1'b1);
    rst = 1'b1;
    #1;
    check1("arst_busy", o_busy, 1'b0);
    check("arst_crc", o_crc, 32'h0);
    check1("arst_vld", o_vld, 1'b0);
    check1("arst_err", o_err, 1'b0);
    check1("arst_seqerr", o_seqerr, 1'b0);
    #1 rst = 1'b0;
    drive_word(W_C2, 1'b0, 1'b1, 5'd1, 1'b0);
    check1("postrst_vld", o_vld, 1'b0);
    check1("postrst_seqerr", o_seqerr, 1'b1);
    drive_word(W_123, 1'b1, 1'b1, 5'd9, 1'b0);
    check("postrst_crc", o_crc, 32'h649C2FD3);
    check1("postrst_vld2", o_vld, 1'b1);

    // Random lengths against the model; odd packets in check mode with FCS.
    for (int p = 0; p < 16; p++) begin
      len = $urandom_range(200, 1);
      pkt = {};
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(255, 0)));
      chk = p[0];
      if (chk) begin
        std = bitrev(model_crc(pkt));
        for (int i = 0; i < 4; i++) pkt.push_back(std[8*i +: 8]);
        if ((p % 3) == 0) pkt[0] = pkt[0] ^ 8'h01;
      end
      exp_crc = model_crc(pkt);
      exp_err = chk & ((exp_crc ^ 32'hFFFFFFFF) != 32'hC704DD7B);
      send_pkt(pkt, chk, p % 3);
      check1($sformatf("rnd%0d_vld", p), o_vld, 1'b1);
      check($sformatf("rnd%0d_crc", p), o_crc, exp_crc);
      check1($sformatf("rnd%0d_err", p), o_err, exp_err);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
